// File: rtl/led_ctrl_if.sv
// Host/event request bundle for the LED controller.
// The host side drives requests and events; the controller returns req_ready.
interface led_ctrl_if #(
   parameter int PWM_BITS = 4
);
   logic                req_valid;
   logic                req_ready;
   logic [3:0]          req_pattern;
   logic [PWM_BITS-1:0] req_bright;
   logic [15:0]         req_hold_ms;
   logic                evt_valid;
   logic [3:0]          evt_pattern;

   modport master (
      output req_valid, req_pattern, req_bright, req_hold_ms, evt_valid, evt_pattern,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_pattern, req_bright, req_hold_ms, evt_valid, evt_pattern,
      output req_ready
   );
endinterface

// File: rtl/led_ctrl.sv
// LED controller: heartbeat in IDLE, host PWM display in HOST, flashing event
// in EVENT. Events preempt everything; the LED pins are registered, active-low.
module led_ctrl #(
   parameter int TICK_DIV    = 100000,
   parameter int PWM_BITS    = 4,
   parameter int EVT_ON_MS   = 100,
   parameter int EVT_FLASHES = 3,
   parameter int HB_BIT      = 9
) (
   input  logic       clk,
   input  logic       resetn,
   led_ctrl_if.slave  bus,
   output logic [3:0] led_n,
   output logic       busy
);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FL_W  = (EVT_FLASHES > 1) ? $clog2(EVT_FLASHES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_HOST, S_EVENT} state_t;

   state_t              state_q, state_d;
   logic [PRE_W-1:0]    presc_q;
   logic [PWM_BITS-1:0] pwm_q;
   logic [15:0]         hb_q;
   logic [3:0]          pat_q, pat_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic [15:0]         hold_q, hold_d;
   logic [3:0]          ev_pat_q, ev_pat_d;
   logic [FL_W-1:0]     flash_q, flash_d;
   logic                phase_on_q, phase_on_d;
   logic [15:0]         phase_cnt_q, phase_cnt_d;
   logic [3:0]          led_n_q;
   logic                busy_q;

   logic                tick;
   logic                req_fire;
   logic [3:0]          mask;
   logic [PWM_BITS-1:0] br;
   logic                pwm_on;
   logic                unused_hb;

   assign tick          = (presc_q == PRE_W'(TICK_DIV - 1));
   assign bus.req_ready = resetn && (state_q != S_EVENT) && !bus.evt_valid;
   assign req_fire      = bus.req_valid && bus.req_ready;
   assign led_n         = led_n_q;
   assign busy          = busy_q;
   // Only one heartbeat bit drives the LED; the rest just keep counting.
   assign unused_hb     = ^hb_q;

   // Free-running timebases: ms prescaler, PWM ramp, heartbeat tick counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q <= '0;
         pwm_q   <= '0;
         hb_q    <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         pwm_q   <= pwm_q + 1'b1;
         if (tick) hb_q <= hb_q + 16'd1;
      end
   end

   // Arbitration and per-state timers: event > host request > heartbeat.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      bright_d    = bright_q;
      hold_d      = hold_q;
      ev_pat_d    = ev_pat_q;
      flash_d     = flash_q;
      phase_on_d  = phase_on_q;
      phase_cnt_d = phase_cnt_q;
      if (bus.evt_valid) begin
         state_d     = S_EVENT;
         ev_pat_d    = bus.evt_pattern;
         flash_d     = '0;
         phase_on_d  = 1'b1;
         phase_cnt_d = 16'(EVT_ON_MS);
      end else if (req_fire) begin
         state_d  = S_HOST;
         pat_d    = bus.req_pattern;
         bright_d = bus.req_bright;
         hold_d   = bus.req_hold_ms;
      end else begin
         case (state_q)
            S_HOST: begin
               // hold of 0 means persistent: never decrements, never expires
               if (tick && hold_q != 16'd0) begin
                  hold_d = hold_q - 16'd1;
                  if (hold_q == 16'd1) state_d = S_IDLE;
               end
            end
            S_EVENT: begin
               if (tick && phase_cnt_q != 16'd0) begin
                  if (phase_cnt_q == 16'd1) begin
                     phase_cnt_d = 16'(EVT_ON_MS);
                     phase_on_d  = !phase_on_q;
                     // an off phase just finished: one flash complete
                     if (!phase_on_q) begin
                        if (flash_q == FL_W'(EVT_FLASHES - 1)) begin
                           state_d = S_IDLE;
                           flash_d = '0;
                        end else begin
                           flash_d = flash_q + 1'b1;
                        end
                     end
                  end else begin
                     phase_cnt_d = phase_cnt_q - 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and latched request/event registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         bright_q    <= '0;
         hold_q      <= '0;
         ev_pat_q    <= '0;
         flash_q     <= '0;
         phase_on_q  <= 1'b0;
         phase_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         bright_q    <= bright_d;
         hold_q      <= hold_d;
         ev_pat_q    <= ev_pat_d;
         flash_q     <= flash_d;
         phase_on_q  <= phase_on_d;
         phase_cnt_q <= phase_cnt_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   // Select mask and brightness for the current state, then apply PWM.
   always_comb begin
      mask = '0;
      br   = '1;
      case (state_q)
         S_IDLE:  mask = hb_q[HB_BIT] ? 4'b0001 : 4'b0000;
         S_HOST:  begin mask = pat_q; br = bright_q; end
         S_EVENT: mask = phase_on_q ? ev_pat_q : 4'b0000;
         default: ;
      endcase
      // all-ones is forced fully on; otherwise on for 'br' of every 2^PWM_BITS clocks
      pwm_on = (br == '1) || (pwm_q < br);
   end

   // Registered active-low LED drive.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) led_n_q <= 4'b1111;
      else         led_n_q <= ~(mask & {4{pwm_on}});
   end
endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against an elapsed-time model of the controller.
module tb_led_ctrl;
   localparam int TD = 10, PB = 4, ON = 3, FL = 2, HB = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] led_n;
   logic       busy;

   led_ctrl_if #(.PWM_BITS(PB)) bus ();

   led_ctrl #(.TICK_DIV(TD), .PWM_BITS(PB), .EVT_ON_MS(ON), .EVT_FLASHES(FL), .HB_BIT(HB)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .led_n(led_n), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 idle, 1 host, 2 event.
   int         e;          // clock edges since reset release
   int         mode;
   int         hold_left;  // ticks of host display remaining (0 = persistent)
   int         ev_el;      // ticks elapsed since the event started
   logic [3:0] h_pat, h_br, ev_pat, exp_led;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic mreset();
      e = 0; mode = 0; hold_left = 0; ev_el = 0;
      h_pat = 0; h_br = 0; ev_pat = 0; exp_led = 4'hF;
   endtask

   function automatic logic [3:0] model_lit();
      int         pwm, hb;
      logic [3:0] m;
      pwm = e % 16;
      hb  = e / TD;
      m   = 4'h0;
      case (mode)
         0: m = ((hb >> HB) & 1) ? 4'b0001 : 4'b0000;
         1: m = (h_br == 4'hF || pwm < int'(h_br)) ? h_pat : 4'b0000;
         default: m = (((ev_el / ON) % 2) == 0) ? ev_pat : 4'b0000;
      endcase
      return m;
   endfunction

   // One clock edge of the model, using the inputs currently applied.
   task automatic model_edge();
      bit t, rdy;
      exp_led = ~model_lit();
      rdy = (mode != 2) && !bus.evt_valid;
      e++;
      t = (e % TD) == 0;
      if (bus.evt_valid) begin
         mode = 2; ev_pat = bus.evt_pattern; ev_el = 0;
      end else if (bus.req_valid && rdy) begin
         mode = 1; h_pat = bus.req_pattern; h_br = bus.req_bright; hold_left = bus.req_hold_ms;
      end else if (mode == 1 && t && hold_left != 0) begin
         hold_left--;
         if (hold_left == 0) mode = 0;
      end else if (mode == 2 && t) begin
         ev_el++;
         if (ev_el == 2 * FL * ON) mode = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("led_n", 16'(led_n), 16'(exp_led));
      chk("busy", 16'(busy), 16'(mode != 0));
      chk("req_ready", 16'(bus.req_ready), 16'((mode != 2) && !bus.evt_valid));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_in();
      bus.req_valid = 0; bus.evt_valid = 0;
   endtask

   task automatic req(input logic [3:0] p, input logic [3:0] b, input logic [15:0] h);
      bus.req_valid = 1; bus.req_pattern = p; bus.req_bright = b; bus.req_hold_ms = h;
      step();
      bus.req_valid = 0;
   endtask

   task automatic evt(input logic [3:0] p);
      bus.evt_valid = 1; bus.evt_pattern = p;
      step();
      bus.evt_valid = 0;
   endtask

   initial begin
      clear_in();
      bus.req_pattern = 0; bus.req_bright = 0; bus.req_hold_ms = 0; bus.evt_pattern = 0;
      mreset();
      #12;
      chk("rst_led_n", 16'(led_n), 16'h000F);
      chk("rst_busy", 16'(busy), 16'h0000);
      chk("rst_ready", 16'(bus.req_ready), 16'h0000);
      @(negedge clk);
      resetn = 1;
      mreset();

      run(100);                       // heartbeat
      req(4'b1010, 4'hF, 16'd5);      // full-bright timed display
      run(70);
      req(4'b1111, 4'd4, 16'd0);      // 4/16 duty
      run(48);
      req(4'b1111, 4'd0, 16'd0);      // brightness 0 is dark
      run(20);
      req(4'b0011, 4'hF, 16'd0);      // replace persistent request
      run(30);
      evt(4'b1111);                   // preempt host
      run(150);
      bus.req_valid = 1; bus.req_pattern = 4'b0110; bus.req_bright = 4'hF; bus.req_hold_ms = 16'd3;
      evt(4'b0101);                   // simultaneous: event wins
      run(20);

      // async reset in the middle of the event
      resetn = 0;
      #1;
      chk("midrst_led_n", 16'(led_n), 16'h000F);
      chk("midrst_busy", 16'(busy), 16'h0000);
      chk("midrst_ready", 16'(bus.req_ready), 16'h0000);
      repeat (3) @(negedge clk);
      chk("inrst_led_n", 16'(led_n), 16'h000F);
      resetn = 1;
      mreset();
      run(20);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.evt_valid   = ($urandom_range(0, 249) == 0);
         bus.evt_pattern = 4'($urandom_range(0, 15));
         bus.req_valid   = ($urandom_range(0, 24) == 0);
         bus.req_pattern = 4'($urandom_range(0, 15));
         bus.req_bright  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         bus.req_hold_ms = 16'($urandom_range(0, 8));
         step();
      end
      clear_in();
      run(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
